// File: rtl/reg_pipe_if.sv
// reg_pipe_if: handshake bundle carried between producer, reg_pipe and consumer.
// Ports: flush, in_vld/in_rdy/in_data (upstream), out_vld/out_rdy/out_data (downstream), occ.
interface reg_pipe_if #(
  parameter int dw = 8,
  parameter int depth = 2
);
  localparam int cw = $clog2(depth + 1);

  logic          flush;
  logic          in_vld;
  logic          in_rdy;
  logic [dw-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [dw-1:0] out_data;
  logic [cw-1:0] occ;

  modport slave (
    input  flush,
    input  in_vld,
    input  in_data,
    input  out_rdy,
    output in_rdy,
    output out_vld,
    output out_data,
    output occ
  );

  modport master (
    output flush,
    output in_vld,
    output in_data,
    output out_rdy,
    input  in_rdy,
    input  out_vld,
    input  out_data,
    input  occ
  );
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: elastic depth-stage register chain, valid/ready both sides, bubble collapse, flush.
// Ports: clk, rstn (async active-low), bus (reg_pipe_if.slave: handshake, flush, occupancy).
module reg_pipe #(
  parameter int dw = 8,
  parameter int depth = 2,
  localparam int cw = $clog2(depth + 1)
) (
  input logic       clk,
  input logic       rstn,
  reg_pipe_if.slave bus
);

  logic [depth-1:0] vld;
  logic [dw-1:0]    dat [depth];
  logic [depth-1:0] go;
  logic [depth-1:0] pv;
  logic [dw-1:0]    pd [depth];
  logic [cw-1:0]    cnt;

  // Stage k may load when it is empty or its successor advances;
  // the ripple from out_rdy back to in_rdy is combinational.
  always_comb begin : ready_chain
    logic g;
    g  = bus.out_rdy & ~bus.flush;
    go = '0;
    for (int k = depth - 1; k >= 0; k--) begin
      g     = ~bus.flush & (~vld[k] | g);
      go[k] = g;
    end
  end

  // Source feeding each stage: upstream port for stage 0,
  // previous stage otherwise.
  always_comb begin
    pv[0] = bus.in_vld;
    pd[0] = bus.in_data;
    for (int k = 1; k < depth; k++) begin
      pv[k] = vld[k-1];
      pd[k] = dat[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      for (int k = 0; k < depth; k++) begin
        dat[k] <= '0;
      end
    end else if (bus.flush) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < depth; k++) begin
        if (go[k]) begin
          vld[k] <= pv[k];
          if (pv[k]) begin
            dat[k] <= pd[k];
          end
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < depth; k++) begin
      cnt = cnt + cw'(vld[k]);
    end
  end

  assign bus.in_rdy   = go[0];
  assign bus.out_vld  = vld[depth-1] & ~bus.flush;
  assign bus.out_data = dat[depth-1];
  assign bus.occ      = cnt;

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: scoreboard bench for reg_pipe (depth 3 x 8 bit, depth 1 x 16 bit).
// Reference model: queue of accepted items with accept cycle.
module tb_reg_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors = 0;
  int nb_out = 0;

  reg_pipe_if #(.dw(8), .depth(3))  a();
  reg_pipe_if #(.dw(16), .depth(1)) b();

  reg_pipe #(.dw(8), .depth(3)) ua (
    .clk(clk), .rstn(rstn), .bus(a)
  );
  reg_pipe #(.dw(16), .depth(1)) ub (
    .clk(clk), .rstn(rstn), .bus(b)
  );

  typedef struct {
    logic [15:0] d;
    int          c;
  } item_t;

  item_t qa[$];
  item_t qb[$];
  item_t ea, eb;
  int    na, nb;
  int    stall_a = -1;
  int    stall_b = -1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard for the depth-3 pipe.
  always @(negedge clk) begin
    if (!rstn) begin
      qa.delete();
    end else begin
      na = qa.size();
      chk("a_occ", a.occ, na);
      chk("a_in_rdy", a.in_rdy, !a.flush && (na < 3 || a.out_rdy));
      if (a.flush || na == 0) chk("a_out_vld_idle", a.out_vld, 0);
      if (a.out_vld && a.out_rdy && na > 0) begin
        ea = qa.pop_front();
        chk("a_data", a.out_data, ea.d);
        if (ea.c > stall_a) chk("a_latency", cyc - ea.c, 3);
        else chk("a_latency_min", (cyc - ea.c) >= 3, 1);
      end
      if (!a.out_rdy) stall_a = cyc;
      if (a.flush) qa.delete();
      else if (a.in_vld && a.in_rdy)
        qa.push_back('{d: 16'(a.in_data), c: cyc});
    end
  end

  // Monitor / scoreboard for the depth-1 pipe.
  always @(negedge clk) begin
    if (!rstn) begin
      qb.delete();
    end else begin
      nb = qb.size();
      chk("b_occ", b.occ, nb);
      chk("b_in_rdy", b.in_rdy, !b.flush && (nb < 1 || b.out_rdy));
      if (b.flush || nb == 0) chk("b_out_vld_idle", b.out_vld, 0);
      if (b.out_vld && b.out_rdy && nb > 0) begin
        eb = qb.pop_front();
        nb_out++;
        chk("b_data", b.out_data, eb.d);
        if (eb.c > stall_b) chk("b_latency", cyc - eb.c, 1);
        else chk("b_latency_min", (cyc - eb.c) >= 1, 1);
      end
      if (!b.out_rdy) stall_b = cyc;
      if (b.flush) qb.delete();
      else if (b.in_vld && b.in_rdy)
        qb.push_back('{d: b.in_data, c: cyc});
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    int k;
    logic acc;
    int snap;
    a.flush = 0; a.in_vld = 0; a.in_data = '0; a.out_rdy = 0;
    b.flush = 0; b.in_vld = 0; b.in_data = '0; b.out_rdy = 0;

    // reset state
    #12;
    chk("rst_occ", a.occ, 0);
    chk("rst_out_vld", a.out_vld, 0);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_in_rdy", a.in_rdy, 1);
    step();
    rstn = 1;

    // full-rate stream
    a.out_rdy = 1;
    for (int i = 1; i <= 10; i++) begin
      a.in_vld = 1;
      a.in_data = 8'(i);
      step();
    end
    a.in_vld = 0;
    repeat (5) step();

    // back-pressure: fourth word waits for space
    a.out_rdy = 0;
    a.in_vld = 1;
    a.in_data = 8'hA1; step();
    a.in_data = 8'hA2; step();
    a.in_data = 8'hA3; step();
    a.in_data = 8'hA4; step();
    chk("full_occ", a.occ, 3);
    chk("full_in_rdy", a.in_rdy, 0);
    step();
    a.out_rdy = 1;
    step();
    a.in_vld = 0;
    repeat (6) step();

    // bubble collapse
    a.out_rdy = 0;
    a.in_vld = 1; a.in_data = 8'h10; step();
    a.in_vld = 0; step();
    a.in_vld = 1; a.in_data = 8'h11; step();
    a.in_vld = 0; step();
    step();
    chk("bub_occ", a.occ, 2);
    a.out_rdy = 1;
    @(negedge clk);
    chk("bub_out0", {a.out_vld, a.out_data}, {1'b1, 8'h10});
    @(negedge clk);
    chk("bub_out1", {a.out_vld, a.out_data}, {1'b1, 8'h11});
    repeat (3) step();

    // flush while full with a pending input
    a.out_rdy = 0;
    a.in_vld = 1;
    a.in_data = 8'hC1; step();
    a.in_data = 8'hC2; step();
    a.in_data = 8'hC3; step();
    chk("fl_occ_pre", a.occ, 3);
    a.flush = 1;
    a.in_data = 8'h55;
    #1;
    chk("fl_in_rdy", a.in_rdy, 0);
    chk("fl_out_vld", a.out_vld, 0);
    step();
    a.flush = 0;
    a.in_vld = 0;
    chk("fl_occ_post", a.occ, 0);
    a.out_rdy = 1;
    repeat (5) step();

    // asynchronous reset mid-stream
    a.out_rdy = 0;
    a.in_vld = 1;
    a.in_data = 8'hD1; step();
    a.in_data = 8'hD2; step();
    a.in_vld = 0;
    chk("rs_occ_pre", a.occ, 2);
    #2;
    rstn = 0;
    #1;
    chk("rs_out_vld", a.out_vld, 0);
    chk("rs_out_data", a.out_data, 0);
    chk("rs_occ", a.occ, 0);
    step();
    rstn = 1;
    a.out_rdy = 1;
    a.in_vld = 1; a.in_data = 8'h77; step();
    a.in_vld = 0;
    repeat (5) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a.in_vld  = ($urandom_range(0, 3) != 0);
      a.in_data = 8'($urandom);
      a.out_rdy = ($urandom_range(0, 2) != 0);
      a.flush   = ($urandom_range(0, 31) == 0);
      step();
    end
    a.flush = 0;
    a.in_vld = 0;
    a.out_rdy = 1;
    for (int i = 0; i < 20 && qa.size() != 0; i++) step();
    chk("a_drain", qa.size(), 0);

    // depth 1, alternating out_rdy
    k = 0;
    b.in_vld = 1;
    b.in_data = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      b.out_rdy = (i % 2 == 0);
      @(negedge clk);
      acc = b.in_rdy;
      step();
      if (acc) begin
        k++;
        b.in_data = 16'h1234 + 16'(k) * 16'h4444;
      end
    end
    snap = nb_out;
    chk("b_rate", snap, 9);
    b.in_vld = 0;
    b.out_rdy = 1;
    for (int i = 0; i < 10 && qb.size() != 0; i++) step();
    chk("b_drain", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
